// File: rtl/clock_run_sched.sv
// clock_run_sched: round-robin cycle-run scheduler driving a gated DUT clock enable.
//   clock, reset          : clock and async active-high reset
//   req_valid/req_count   : per-requester run request and run length (slice i*CNT_W)
//   req_ready             : combinational one-hot accept for the IDLE winner
//   abort                 : cut the current run short
//   clk_en, busy, owner   : registered enable, non-IDLE flag, current/last owner
//   remaining             : cycles left in the current run
//   done, done_aborted    : one-cycle completion pulse to owner, abort qualifier
//   cycles_total          : wrapping count of enabled cycles
module clock_run_sched #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*CNT_W-1:0] req_count,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  abort,
    output logic                  clk_en,
    output logic                  busy,
    output logic [2:0]            owner,
    output logic [CNT_W-1:0]      remaining,
    output logic [NREQ-1:0]       done,
    output logic                  done_aborted,
    output logic [31:0]           cycles_total
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [2:0] last_grant, win, owner_n;
    logic any, accept;
    logic [CNT_W-1:0] win_count;
    // Scan from farthest to nearest so the first valid index after last_grant wins.
    always_comb begin
        win = last_grant;
        any = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_grant) + k) % NREQ;
            if (|(req_valid & (NREQ'(1) << idx))) begin
                win = 3'(idx);
                any = 1'b1;
            end
        end
        accept    = (state == IDLE) && any;
        req_ready = accept ? NREQ'(1) << win : '0;
        win_count = CNT_W'(req_count >> (int'(win) * CNT_W));
        owner_n   = accept ? win : owner;
        state_n   = state == IDLE ? (accept ? (win_count == '0 ? DONE : RUN) : IDLE)
                  : state == RUN  ? ((abort || remaining == CNT_W'(1)) ? DONE : RUN)
                  : IDLE;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            clk_en       <= 1'b0;
            busy         <= 1'b0;
            owner        <= '0;
            remaining    <= '0;
            done         <= '0;
            done_aborted <= 1'b0;
            cycles_total <= '0;
            last_grant   <= 3'(NREQ - 1);
        end else begin
            state        <= state_n;
            clk_en       <= state_n == RUN;
            busy         <= state_n != IDLE;
            owner        <= owner_n;
            done         <= (state_n == DONE && state != DONE) ? NREQ'(1) << owner_n : '0;
            done_aborted <= state == RUN && abort;
            if (clk_en)
                cycles_total <= cycles_total + 32'd1;
            if (accept) begin
                last_grant <= win;
                remaining  <= win_count;
            end else if (state == RUN)
                remaining <= abort ? '0 : remaining - CNT_W'(1);
        end
    end
endmodule

// File: doc/clock_run_sched.md
# clock_run_sched

Cycle-run scheduler sitting between the RPC-driven testbench endpoints and the DUT clock domain of the smoke/HDL test harness. Up to NREQ requesters each ask for "advance N clock cycles"; the block arbitrates round-robin, grants one request at a time, and drives a clock-enable for exactly N cycles. Completion is reported back to the owning requester. A global 32-bit enabled-cycle counter serves as the simulation-time reference for the RPC layer.

## Interface
- NREQ, 2, number of requesters (1..8)
- CNT_W, 16, width of a run-length request

- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NREQ  requester i has a run request pending
- req_count  in  NREQ*CNT_W  run length for requester i, slice [i*CNT_W +: CNT_W]
- req_ready  out  NREQ  one-hot accept for the granted requester
- abort  in  1  terminate current run early
- clk_en  out  1  registered enable for the gated DUT clock
- busy  out  1  high in any state other than IDLE
- owner  out  3  index of current or last granted requester
- remaining  out  CNT_W  cycles left in current run
- done  out  NREQ  one-cycle completion pulse to owner
- done_aborted  out  1  qualifies done: run was cut short by abort
- cycles_total  out  32  count of cycles with clk_en high, wraps at 2^32

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, clk_en 0, busy 0, owner 0, remaining 0, done 0, done_aborted 0, cycles_total 0, internal last_grant = NREQ-1 (requester 0 wins first).
- IDLE: req_ready combinational; asserted only for the winner, the first valid index searching last_grant+1, +2, ... mod NREQ. No valid -> req_ready all 0.
- Accept = req_valid[w] & req_ready[w]. On accept: owner<=w, last_grant<=w, remaining<=req_count[w]; count 0 -> DONE, else -> RUN.
- RUN: clk_en high; remaining decrements each cycle; cycles_total increments each cycle clk_en is high. When remaining==1 -> DONE. req_ready all 0.
- abort in RUN: next state DONE, remaining<=0, done_aborted set with done. abort in IDLE or DONE ignored.
- DONE: done[owner]=1, clk_en 0, then -> IDLE. done_aborted 1 only if entered via abort.
- Requesters hold req_valid and req_count stable until accepted; dropping valid before accept is allowed and simply removes the requester from arbitration.
- req_count max 2^CNT_W-1; no overflow possible in remaining (down-counter only).
- cycles_total wraps silently 0xFFFFFFFF -> 0.
- Reset mid-run: clk_en drops asynchronously, no done pulse issued; requester must re-request.

## Timing
- Accept at edge T (state IDLE at T). clk_en high cycles T+1..T+N, done pulse cycle T+N+1, IDLE at T+N+2. Next accept earliest at edge T+N+2. Total turnaround N+2 cycles.
- count 0: DONE at T+1, done pulse T+1, clk_en never rises.
- abort sampled high at edge in RUN: clk_en low from the following cycle; the cycle abort is sampled still counts as enabled.
- clk_en, done, done_aborted, busy, remaining, owner are all registered; only req_ready is combinational.
- Simultaneous requests: exactly one granted per IDLE cycle; others keep waiting, order strictly round-robin.

## Test plan
- Reset then req_valid[0]=1, count=5 -> clk_en high exactly 5 cycles, done[0] pulse 1 cycle later, cycles_total=5, busy low after.
- Both requesters valid, counts 3 and 4, held -> grant order 0,1,0,1...; each run's clk_en width matches its count; no cycle with clk_en high between runs' DONE/IDLE.
- count=0 from requester 1 -> done[1] the cycle after accept, clk_en never high, cycles_total unchanged.
- count=10, abort at 4th enabled cycle -> clk_en high 4 cycles, done pulse with done_aborted=1, remaining=0.
- Assert reset during RUN with remaining=7 -> clk_en, busy, done 0 immediately, cycles_total 0, next request from requester 0 wins.
- Preload by running 0xFFFF-count runs to near 2^32 (or force counter) -> cycles_total wraps 0xFFFFFFFF to 0 without disturbing the run.
